// File: rtl/axis_to_pull.sv
// AXI-stream to pull-interface buffer: stream words into a block RAM and
// hand them out one per cycle on request, with a 1-cycle read latency.
module axis_to_pull #(
    parameter int WIDTH     = 8,
    parameter int SIZE_LOG2 = 10,
    parameter int AEMPTY    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 underflow,
    input  logic [WIDTH-1:0]     idata,
    input  logic                 ivalid,
    output logic                 iready,
    output logic [WIDTH-1:0]     odata,
    output logic                 ovalid,
    input  logic                 oenable,
    output logic                 oaempty,
    output logic [SIZE_LOG2:0]   count
);

    localparam int                DEPTH  = 1 << SIZE_LOG2;
    localparam logic [SIZE_LOG2:0] FULL   = (SIZE_LOG2+1)'(DEPTH);
    localparam logic [SIZE_LOG2:0] AE_LVL = (SIZE_LOG2+1)'(AEMPTY);
    localparam logic [SIZE_LOG2:0] CNT_ONE = (SIZE_LOG2+1)'(1);
    localparam logic [SIZE_LOG2-1:0] PTR_ONE = SIZE_LOG2'(1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [SIZE_LOG2-1:0] waddr;
    logic [SIZE_LOG2-1:0] raddr;
    logic                 accept;
    logic                 read;

    // Ready looks only at the registered count, so a read while full does
    // not reopen the input until the next cycle; this keeps waddr != raddr.
    assign iready  = (count != FULL) && !reset;
    assign accept  = ivalid && iready;
    assign read    = oenable && (count != '0);
    assign oaempty = (count <= AE_LVL);

    // RAM array carries no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[waddr] <= idata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            waddr     <= '0;
            raddr     <= '0;
            count     <= '0;
            underflow <= 1'b0;
            ovalid    <= 1'b0;
            odata     <= '0;
        end else begin
            ovalid <= read;
            if (read) begin
                odata <= mem[raddr];
                raddr <= raddr + PTR_ONE;
            end
            if (accept) begin
                waddr <= waddr + PTR_ONE;
            end
            if (oenable && (count == '0)) begin
                underflow <= 1'b1;
            end
            unique case ({accept, read})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_to_pull.sv
// Randomized self-checking bench for axis_to_pull against a queue-based model.
module tb_axis_to_pull;

    localparam int W   = 8;
    localparam int SL  = 2;
    localparam int AE  = 1;
    localparam int DEP = 1 << SL;

    logic          clock = 1'b0;
    logic          reset;
    logic          underflow;
    logic [W-1:0]  idata;
    logic          ivalid;
    logic          iready;
    logic [W-1:0]  odata;
    logic          ovalid;
    logic          oenable;
    logic          oaempty;
    logic [SL:0]   count;

    axis_to_pull #(.WIDTH(W), .SIZE_LOG2(SL), .AEMPTY(AE)) dut (
        .clock(clock), .reset(reset), .underflow(underflow),
        .idata(idata), .ivalid(ivalid), .iready(iready),
        .odata(odata), .ovalid(ovalid), .oenable(oenable),
        .oaempty(oaempty), .count(count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] m_odata = '0;
    logic         m_ovalid = 1'b0;
    logic         m_uflow = 1'b0;
    logic         last_acc;
    logic [W-1:0] outs[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: check ready, advance the model, clock the DUT, check outputs.
    task automatic step(input logic rst, input logic v, input logic [W-1:0] d, input logic en);
        logic m_ready, acc, rd;
        reset = rst; ivalid = v; idata = d; oenable = en;
        #1;
        m_ready = (q.size() != DEP) && !rst;
        chk("iready", 32'(iready), 32'(m_ready));
        acc = v && m_ready;
        rd  = en && (q.size() != 0);
        if (rst) begin
            q.delete();
            m_odata = '0; m_ovalid = 1'b0; m_uflow = 1'b0;
        end else begin
            m_ovalid = rd;
            if (rd) begin
                m_odata = q.pop_front();
                outs.push_back(m_odata);
            end
            if (en && !rd) m_uflow = 1'b1;
            if (acc) q.push_back(d);
        end
        last_acc = acc;
        @(posedge clock);
        #1;
        chk("count",     32'(count),     32'(q.size()));
        chk("ovalid",    32'(ovalid),    32'(m_ovalid));
        chk("odata",     32'(odata),     32'(m_odata));
        chk("underflow", 32'(underflow), 32'(m_uflow));
        chk("oaempty",   32'(oaempty),   32'(q.size() <= AE));
    endtask

    task automatic idle(); step(1'b0, 1'b0, '0, 1'b0); endtask

    task automatic push(input logic [W-1:0] d);
        int guard = 0;
        do begin
            step(1'b0, 1'b1, d, 1'b0);
            guard++;
        end while (!last_acc && guard < 50);
        if (!last_acc) chk("push_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1; ivalid = 1'b0; idata = '0; oenable = 1'b0;
        @(negedge clock);

        // Reset then idle, then underflow
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        idle();
        chk("rst_count", 32'(count), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("uflow_set", 32'(underflow), 32'd1);
        repeat (20) idle();
        step(1'b1, 1'b0, '0, 1'b0);
        chk("uflow_clr", 32'(underflow), 32'd0);

        // Fill, then a 5th word held off for a few cycles
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("full_cnt", 32'(count), 32'd4);
        repeat (3) step(1'b0, 1'b1, 8'h55, 1'b0);
        chk("full_cnt2", 32'(count), 32'd4);

        // Drain back-to-back
        outs.delete();
        repeat (4) step(1'b0, 1'b0, '0, 1'b1);
        idle();
        chk("drain_n", 32'(outs.size()), 32'd4);
        for (int i = 0; i < 4 && i < outs.size(); i++)
            chk("drain_data", 32'(outs[i]), 32'(8'h11 * (i + 1)));

        // Wrap-around with random handshakes
        begin
            int nxt = 0;
            int cyc = 0;
            outs.delete();
            while ((nxt < 10 || q.size() != 0) && cyc < 500) begin
                logic v, en;
                v  = (nxt < 10) && ($urandom_range(0, 3) != 0);
                en = (q.size() != 0) && ($urandom_range(0, 2) != 0);
                step(1'b0, v, W'(nxt), en);
                if (last_acc) nxt++;
                cyc++;
            end
            idle();
            chk("wrap_n", 32'(outs.size()), 32'd10);
            for (int i = 0; i < 10 && i < outs.size(); i++)
                chk("wrap_data", 32'(outs[i]), 32'(i));
            chk("wrap_uflow", 32'(underflow), 32'd0);
        end

        // Simultaneous accept and read at count=2
        push(8'hC1); push(8'hC2);
        step(1'b0, 1'b1, 8'hC3, 1'b1);
        chk("sim_cnt", 32'(count), 32'd2);
        chk("sim_data", 32'(odata), 32'hC1);
        push(8'hC4); push(8'hC5);
        step(1'b0, 1'b1, 8'hC6, 1'b1);
        chk("full_rd_cnt", 32'(count), 32'd3);
        chk("full_rd_data", 32'(odata), 32'hC2);
        step(1'b0, 1'b1, 8'hC6, 1'b0);
        chk("full_rd_acc", 32'(last_acc), 32'd1);
        repeat (4) step(1'b0, 1'b0, '0, 1'b1);
        idle();

        // Reset mid-stream with count=3 and oenable high
        push(8'h01); push(8'h02); push(8'h03);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("mid_ovalid", 32'(ovalid), 32'd0);
        chk("mid_count", 32'(count), 32'd0);
        idle();
        push(8'hA5);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("a5_valid", 32'(ovalid), 32'd1);
        chk("a5_data", 32'(odata), 32'hA5);
        idle();

        // Random soak
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1,
                 W'($urandom), $urandom_range(0, 1) == 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
